// File: rtl/ethpipe_pkg.sv
// Shared definitions for the ethpipe frame-slot datapath (TX transmitter and RX slot writer).
package ethpipe_pkg;

    localparam int unsigned TS_LO = 32'd0;
    localparam int unsigned TS_HI = 32'd1;
    localparam int unsigned HASH  = 32'd2;
    localparam int unsigned LEN   = 32'd3;
    localparam int unsigned DATA  = 32'd4;

    localparam int unsigned LEN_LSB = 32'd16;
    localparam int unsigned LEN_MSB = 32'd26;
    localparam int unsigned LEN_W   = 32'd11;

    localparam logic [7:0] PREAMBLE = 8'h55;
    localparam logic [7:0] SFD      = 8'hD5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_WAIT = 3'd2,
        ST_PRE  = 3'd3,
        ST_DATA = 3'd4,
        ST_IFG  = 3'd5,
        ST_DONE = 3'd6
    } tx_state_t;

    function automatic logic [LEN_W-1:0] slot_len(input logic [31:0] word);
        return word[LEN_MSB:LEN_LSB];
    endfunction

endpackage

// File: rtl/ethpipe_tx_fetch.sv
// Slot RAM read port driver: header reads on request, sequential frame-word prefetch,
// and a byte-lane mux over the most recently returned word.
module ethpipe_tx_fetch
    import ethpipe_pkg::*;
#(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hdr_rd,
    input  logic [1:0]        hdr_word,
    input  logic              data_rd,
    input  logic [1:0]        byte_sel,
    input  logic [31:0]       ram_q,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd_en,
    output logic [7:0]        byte_out
);

    logic [ADDR_W-1:0] data_ptr_r;
    logic              q_vld_r;
    logic [31:0]       word_r;

    // Address/strobe registers, word pointer and return-data capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_addr   <= '0;
            ram_rd_en  <= 1'b0;
            data_ptr_r <= '0;
            q_vld_r    <= 1'b0;
            word_r     <= 32'd0;
        end else begin
            // RAM returns data one cycle after the strobe, so the word lands two edges after the request.
            q_vld_r <= ram_rd_en;
            if (q_vld_r) begin
                word_r <= ram_q;
            end
            if (hdr_rd) begin
                ram_addr   <= ADDR_W'(hdr_word);
                ram_rd_en  <= 1'b1;
                data_ptr_r <= ADDR_W'(DATA);
            end else if (data_rd) begin
                ram_addr   <= data_ptr_r;
                ram_rd_en  <= 1'b1;
                data_ptr_r <= data_ptr_r + ADDR_W'(32'd1);
            end else begin
                ram_rd_en  <= 1'b0;
            end
        end
    end

    // Little-endian lane select.
    always_comb begin
        byte_out = 8'h00;
        case (byte_sel)
            2'd0:    byte_out = word_r[7:0];
            2'd1:    byte_out = word_r[15:8];
            2'd2:    byte_out = word_r[23:16];
            2'd3:    byte_out = word_r[31:24];
            default: byte_out = 8'h00;
        endcase
    end

endmodule

// File: rtl/ethpipe_tx.sv
// GMII frame transmitter: reads one frame from the TX slot RAM, waits for its launch time,
// sends preamble/SFD plus frame bytes, then holds off for the inter-frame gap.
module ethpipe_tx
    import ethpipe_pkg::*;
#(
    parameter int IFG_BYTES = 12,
    parameter int ADDR_W    = 11
) (
    input  logic              gmii_tx_clk,
    input  logic              sys_rst_n,
    input  logic [63:0]       global_counter,
    output logic [ADDR_W-1:0] slot_tx_eth_address,
    output logic              slot_tx_eth_rd_en,
    input  logic [31:0]       slot_tx_eth_q,
    input  logic              tx_ready,
    output logic              tx_complete,
    output logic [7:0]        gmii_txd,
    output logic              gmii_tx_en
);

    localparam int IFG_W = $clog2(IFG_BYTES + 1);

    tx_state_t          state_r;
    logic [2:0]         step_r;
    logic [2:0]         pre_cnt_r;
    logic [LEN_W-1:0]   byte_cnt_r;
    logic [IFG_W-1:0]   ifg_cnt_r;
    logic [63:0]        ts_r;
    logic [LEN_W-1:0]   len_r;

    logic               hdr_rd_s;
    logic               data_rd_s;
    logic [2:0]         cap_idx_s;
    logic               ts_due_s;
    logic [7:0]         byte_s;

    assign cap_idx_s = step_r - 3'd2;
    assign ts_due_s  = (ts_r == 64'd0) || (global_counter >= ts_r);

    // Read requests: header words 0..3 in HDR; frame words paced two bytes ahead of use.
    always_comb begin
        hdr_rd_s  = 1'b0;
        data_rd_s = 1'b0;
        case (state_r)
            ST_HDR:  hdr_rd_s  = (step_r < 3'd4);
            ST_PRE:  data_rd_s = (pre_cnt_r == 3'd5);
            ST_DATA: data_rd_s = (byte_cnt_r[1:0] == 2'd1) &&
                                 (({1'b0, byte_cnt_r} + 12'd3) < {1'b0, len_r});
            default: begin
                hdr_rd_s  = 1'b0;
                data_rd_s = 1'b0;
            end
        endcase
    end

    ethpipe_tx_fetch #(
        .ADDR_W (ADDR_W)
    ) u_fetch (
        .clk       (gmii_tx_clk),
        .rst_n     (sys_rst_n),
        .hdr_rd    (hdr_rd_s),
        .hdr_word  (step_r[1:0]),
        .data_rd   (data_rd_s),
        .byte_sel  (byte_cnt_r[1:0]),
        .ram_q     (slot_tx_eth_q),
        .ram_addr  (slot_tx_eth_address),
        .ram_rd_en (slot_tx_eth_rd_en),
        .byte_out  (byte_s)
    );

    // Transmit FSM with registered GMII and completion outputs.
    always_ff @(posedge gmii_tx_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r     <= ST_IDLE;
            step_r      <= 3'd0;
            pre_cnt_r   <= 3'd0;
            byte_cnt_r  <= '0;
            ifg_cnt_r   <= '0;
            ts_r        <= 64'd0;
            len_r       <= '0;
            tx_complete <= 1'b0;
            gmii_txd    <= 8'h00;
            gmii_tx_en  <= 1'b0;
        end else begin
            tx_complete <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (tx_ready) begin
                        state_r <= ST_HDR;
                        step_r  <= 3'd0;
                    end
                end
                ST_HDR: begin
                    step_r <= step_r + 3'd1;
                    if (cap_idx_s == 3'(TS_LO)) begin
                        ts_r[31:0] <= slot_tx_eth_q;
                    end else if (cap_idx_s == 3'(TS_HI)) begin
                        ts_r[63:32] <= slot_tx_eth_q;
                    end else if (cap_idx_s == 3'(LEN)) begin
                        len_r   <= slot_len(slot_tx_eth_q);
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (len_r == '0) begin
                        state_r     <= ST_DONE;
                        tx_complete <= 1'b1;
                    end else if (ts_due_s) begin
                        state_r    <= ST_PRE;
                        gmii_tx_en <= 1'b1;
                        gmii_txd   <= PREAMBLE;
                        pre_cnt_r  <= 3'd1;
                    end
                end
                ST_PRE: begin
                    if (pre_cnt_r == 3'd7) begin
                        gmii_txd   <= SFD;
                        byte_cnt_r <= '0;
                        state_r    <= ST_DATA;
                    end else begin
                        gmii_txd  <= PREAMBLE;
                        pre_cnt_r <= pre_cnt_r + 3'd1;
                    end
                end
                ST_DATA: begin
                    gmii_txd <= byte_s;
                    if (byte_cnt_r == len_r - 11'd1) begin
                        state_r   <= ST_IFG;
                        ifg_cnt_r <= '0;
                    end else begin
                        byte_cnt_r <= byte_cnt_r + 11'd1;
                    end
                end
                ST_IFG: begin
                    gmii_tx_en <= 1'b0;
                    gmii_txd   <= 8'h00;
                    if (ifg_cnt_r == IFG_W'(IFG_BYTES)) begin
                        state_r     <= ST_DONE;
                        tx_complete <= 1'b1;
                    end else begin
                        ifg_cnt_r <= ifg_cnt_r + IFG_W'(32'd1);
                    end
                end
                ST_DONE: begin
                    // Wait for ready to drop so a stale synchronized level cannot retrigger.
                    if (!tx_ready) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    gmii_tx_en <= 1'b0;
                    gmii_txd   <= 8'h00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ethpipe_tx.sv
// Directed self-checking bench for ethpipe_tx with a behavioural slot RAM and free-running time base.
module tb_ethpipe_tx;
    import ethpipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] gc = 64'd0;
    logic [10:0] addr;
    logic        rd_en;
    logic [31:0] q = 32'd0;
    logic        tx_ready;
    logic        tx_complete;
    logic [7:0]  gmii_txd;
    logic        gmii_tx_en;
    int          cyc = 0;

    logic [31:0] mem [0:2047];
    logic [7:0]  exp_byte [0:2047];
    int          exp_len;

    int checks = 0;
    int errors = 0;

    int r_start, r_en, r_bad_pre, r_bad_dat, r_bubbles, r_done, r_last, r_start_abs, r_last_abs;
    bit r_seen;

    always #5 clk = ~clk;
    always @(posedge clk) gc <= gc + 64'd1;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (rd_en) q <= mem[addr];

    ethpipe_tx #(.IFG_BYTES(12), .ADDR_W(11)) dut (
        .gmii_tx_clk         (clk),
        .sys_rst_n           (rst_n),
        .global_counter      (gc),
        .slot_tx_eth_address (addr),
        .slot_tx_eth_rd_en   (rd_en),
        .slot_tx_eth_q       (q),
        .tx_ready            (tx_ready),
        .tx_complete         (tx_complete),
        .gmii_txd            (gmii_txd),
        .gmii_tx_en          (gmii_tx_en)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic load_frame(input logic [63:0] ts, input int len, input logic [7:0] base);
        logic [10:0] ln;
        ln = len[10:0];
        mem[0] = ts[31:0];
        mem[1] = ts[63:32];
        mem[2] = 32'hDEADBEEF;
        mem[3] = {5'b10101, ln, 16'h5AA5};
        for (int w = 4; w < 4 + 520; w++) mem[w] = 32'hEEEEEEEE;
        for (int n = 0; n < len; n++) begin
            exp_byte[n] = base + n[7:0];
            mem[4 + n / 4][8 * (n % 4) +: 8] = base + n[7:0];
        end
        exp_len = len;
    endtask

    // Caller is at a negedge with the DUT idle; ready rises here, edge T is the next posedge.
    task automatic send_frame(input bit keep_ready);
        int c;
        r_start = -1; r_en = 0; r_bad_pre = 0; r_bad_dat = 0; r_bubbles = 0;
        r_done = -1; r_last = -1; r_start_abs = 0; r_last_abs = 0; r_seen = 1'b0;
        tx_ready = 1'b1;
        @(posedge clk);
        c = 0;
        while (!r_seen && c < 4000) begin
            @(negedge clk);
            if (!keep_ready && c == 2) tx_ready = 1'b0;
            if (gmii_tx_en) begin
                if (r_start < 0) begin
                    r_start = c;
                    r_start_abs = cyc;
                end else if (c != r_last + 1) begin
                    r_bubbles++;
                end
                if (r_en < 7) begin
                    if (gmii_txd !== 8'h55) r_bad_pre++;
                end else if (r_en == 7) begin
                    if (gmii_txd !== 8'hD5) r_bad_pre++;
                end else if ((r_en - 8) >= exp_len || gmii_txd !== exp_byte[r_en - 8]) begin
                    r_bad_dat++;
                end
                r_en++;
                r_last = c;
                r_last_abs = cyc;
            end
            if (tx_complete) begin
                r_seen = 1'b1;
                r_done = c;
            end
            c++;
        end
    endtask

    task automatic check_frame(input string tag, input int exp_start);
        check({tag, "_done_seen"}, 64'(r_seen), 64'd1);
        if (exp_len == 0) begin
            check({tag, "_en_cycles"}, 64'(r_en), 64'd0);
            check({tag, "_done_at"}, 64'(r_done), 64'd7);
        end else begin
            check({tag, "_start"}, 64'(r_start), 64'(exp_start));
            check({tag, "_en_cycles"}, 64'(r_en), 64'(8 + exp_len));
            check({tag, "_bad_preamble"}, 64'(r_bad_pre), 64'd0);
            check({tag, "_bad_bytes"}, 64'(r_bad_dat), 64'd0);
            check({tag, "_bubbles"}, 64'(r_bubbles), 64'd0);
            check({tag, "_complete_lag"}, 64'(r_done - r_last), 64'd13);
        end
    endtask

    initial begin
        int lens [4];
        int stale_en, stale_done, last1, c, en;
        logic [63:0] g0;
        lens = '{1, 61, 62, 63};
        for (int w = 0; w < 2048; w++) mem[w] = 32'd0;
        rst_n = 1'b0;
        tx_ready = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({gmii_txd, gmii_tx_en, tx_complete, rd_en, addr}), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_idle", 64'(dut.state_r === ST_IDLE), 64'd1);
        check("post_reset_outputs", 64'({gmii_txd, gmii_tx_en, tx_complete, rd_en, addr}), 64'd0);

        // immediate send
        load_frame(64'd0, 64, 8'h00);
        send_frame(1'b0);
        check_frame("immediate", 7);

        // scheduled send 1000 cycles ahead
        repeat (2) @(negedge clk);
        g0 = gc;
        load_frame(g0 + 64'd1000, 60, 8'h80);
        send_frame(1'b0);
        check_frame("scheduled", 1000);

        // timestamp already in the past
        repeat (2) @(negedge clk);
        g0 = gc;
        load_frame(g0 - 64'd10, 60, 8'h11);
        send_frame(1'b0);
        check_frame("past_ts", 7);

        // odd lengths
        for (int i = 0; i < 4; i++) begin
            repeat (2) @(negedge clk);
            load_frame(64'd0, lens[i], 8'hA0 + 8'(i * 16));
            send_frame(1'b0);
            check_frame($sformatf("len%0d", lens[i]), 7);
        end

        // zero length
        repeat (2) @(negedge clk);
        load_frame(64'd0, 0, 8'h00);
        send_frame(1'b0);
        check_frame("zero_len", 7);

        // stale ready held after completion
        repeat (2) @(negedge clk);
        load_frame(64'd0, 16, 8'h30);
        send_frame(1'b1);
        check_frame("stale_first", 7);
        stale_en = 0;
        stale_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (gmii_tx_en) stale_en++;
            if (tx_complete) stale_done++;
        end
        check("stale_no_tx_en", 64'(stale_en), 64'd0);
        check("stale_no_complete", 64'(stale_done), 64'd0);
        check("stale_in_done", 64'(dut.state_r === ST_DONE), 64'd1);
        last1 = r_last_abs;
        tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        send_frame(1'b0);
        check_frame("stale_second", 7);
        check("frame_gap_ge_ifg", 64'((r_start_abs - last1 - 1) >= 12), 64'd1);

        // reset in the middle of a frame, at byte 30
        repeat (2) @(negedge clk);
        load_frame(64'd0, 64, 8'h40);
        tx_ready = 1'b1;
        c = 0;
        en = 0;
        while (en < 39 && c < 200) begin
            @(negedge clk);
            if (c == 2) tx_ready = 1'b0;
            if (gmii_tx_en) en++;
            c++;
        end
        check("midrst_reached_byte30", 64'(en), 64'd39);
        check("midrst_byte30", 64'(gmii_txd), 64'h5E);
        #1 rst_n = 1'b0;
        #1 check("midrst_tx_en_async", 64'(gmii_tx_en), 64'd0);
        check("midrst_outputs", 64'({gmii_txd, gmii_tx_en, tx_complete, rd_en, addr}), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_idle", 64'(dut.state_r === ST_IDLE), 64'd1);
        check("midrst_post_outputs", 64'({gmii_txd, gmii_tx_en, tx_complete, rd_en, addr}), 64'd0);
        repeat (2) @(negedge clk);
        load_frame(64'd0, 62, 8'hC3);
        send_frame(1'b0);
        check_frame("after_reset", 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
